// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with mem_req/mem_ready handshake, BNE/LUI/BREAK decode and trap states.
// Optional memory-timeout trap is built when MC_CTRL_TIMEOUT_EN is defined.
module mc_ctrl_fsm #(
   parameter int unsigned OP_W        = 6,
   parameter int unsigned STATE_W     = 6,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    op,
   input  logic [OP_W-1:0]    funct,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_write,
   output logic               iord,
   output logic               ir_write,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               branch_ne,
   output logic [1:0]         pc_source,
   output logic [2:0]         alu_op,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               a_write,
   output logic               b_write,
   output logic               alu_out_load,
   output logic               reg_write,
   output logic               reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic               brk,
   output logic               illegal,
   output logic               mem_timeout,
   output logic [STATE_W-1:0] state_out
);

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_ALU_WB   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_LW_READ  = 4'd6,
      S_LW_WB    = 4'd7,
      S_SW_WRITE = 4'd8,
      S_BEQ      = 4'd9,
      S_BNE      = 4'd10,
      S_JUMP     = 4'd11,
      S_LUI      = 4'd12,
      S_HALT     = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [OP_W-1:0] OP_R     = OP_W'(6'h00);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);
   localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'h0F);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);
   localparam logic [OP_W-1:0] FN_BREAK = OP_W'(6'h0D);

   if (MEM_TIMEOUT < 2) begin : g_bad_cfg
      $error("mc_ctrl_fsm: MEM_TIMEOUT must be at least 2");
   end

   state_t state_q;
   state_t state_d;
   logic   to_fire;
   logic   to_cause;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_RESET;
      else        state_q <= state_d;
   end

`ifdef MC_CTRL_TIMEOUT_EN
   localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   logic [CNT_W-1:0] wait_cnt;
   logic             to_cause_q;
   logic             in_wait;

   assign in_wait = (state_q == S_FETCH) || (state_q == S_LW_READ) || (state_q == S_SW_WRITE);
   assign to_fire = in_wait && !mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

   // Any state change clears the count, so every wait state is entered at zero.
   always_ff @(posedge clk) begin
      if (!reset || (state_d != state_q)) wait_cnt <= '0;
      else if (in_wait && !mem_ready)     wait_cnt <= wait_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset)       to_cause_q <= 1'b0;
      else if (to_fire) to_cause_q <= 1'b1;
   end

   assign to_cause    = to_cause_q;
   assign mem_timeout = to_cause_q;
`else
   assign to_fire     = 1'b0;
   assign to_cause    = 1'b0;
   assign mem_timeout = 1'b0;
`endif

   assign state_out = STATE_W'(state_q);

   always_comb begin
      state_d       = state_q;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      pc_source     = 2'b00;
      alu_op        = 3'b000;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      a_write       = 1'b0;
      b_write       = 1'b0;
      alu_out_load  = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 2'b00;
      brk           = 1'b0;
      illegal       = 1'b0;

      case (state_q)
         S_RESET: state_d = S_FETCH;

         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (to_fire) begin
               state_d = S_TRAP;
            end
         end

         S_DECODE: begin
            a_write      = 1'b1;
            b_write      = 1'b1;
            alu_out_load = 1'b1;
            alu_src_b    = 2'b11;
            if (op == OP_R)                      state_d = (funct == FN_BREAK) ? S_HALT : S_EXEC_R;
            else if (op == OP_LW || op == OP_SW) state_d = S_MEM_ADDR;
            else if (op == OP_BEQ)               state_d = S_BEQ;
            else if (op == OP_BNE)               state_d = S_BNE;
            else if (op == OP_J)                 state_d = S_JUMP;
            else if (op == OP_LUI)               state_d = S_LUI;
            else                                 state_d = S_TRAP;
         end

         S_EXEC_R: begin
            alu_src_a    = 1'b1;
            alu_op       = 3'b010;
            alu_out_load = 1'b1;
            state_d      = S_ALU_WB;
         end

         S_ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end

         S_MEM_ADDR: begin
            alu_src_a    = 1'b1;
            alu_src_b    = 2'b10;
            alu_out_load = 1'b1;
            state_d      = (op == OP_SW) ? S_SW_WRITE : S_LW_READ;
         end

         S_LW_READ: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready)    state_d = S_LW_WB;
            else if (to_fire) state_d = S_TRAP;
         end

         S_LW_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            state_d    = S_FETCH;
         end

         S_SW_WRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready)    state_d = S_FETCH;
            else if (to_fire) state_d = S_TRAP;
         end

         S_BEQ, S_BNE: begin
            alu_src_a     = 1'b1;
            alu_op        = 3'b001;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            branch_ne     = (state_q == S_BNE);
            state_d       = S_FETCH;
         end

         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = S_FETCH;
         end

         S_LUI: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
            state_d    = S_FETCH;
         end

         S_HALT: brk = 1'b1;

         S_TRAP: illegal = !to_cause;

         default: state_d = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction expected cycle traces with random wait states.
// Timeout scenarios are exercised when MC_CTRL_TIMEOUT_EN is defined (DUT built with MEM_TIMEOUT=4).
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] op = '0;
   logic [5:0] funct = '0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne;
   logic [1:0] pc_source;
   logic [2:0] alu_op;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       a_write, b_write, alu_out_load, reg_write, reg_dst;
   logic [1:0] mem_to_reg;
   logic       brk, illegal, mem_timeout;
   logic [5:0] state_out;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.OP_W(6), .STATE_W(6), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
      .pc_source(pc_source), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .a_write(a_write), .b_write(b_write), .alu_out_load(alu_out_load),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .brk(brk), .illegal(illegal), .mem_timeout(mem_timeout), .state_out(state_out)
   );

   typedef struct packed {
      logic       mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       a_write, b_write, alu_out_load, reg_write, reg_dst;
      logic [1:0] mem_to_reg;
      logic       brk, illegal, mem_timeout;
   } strb_t;

   typedef struct {
      logic [5:0] code;
      logic       rdy;
      strb_t      exp;
   } step_t;

   strb_t act;
   always_comb act = {mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne,
                      pc_source, alu_op, alu_src_a, alu_src_b, a_write, b_write, alu_out_load,
                      reg_write, reg_dst, mem_to_reg, brk, illegal, mem_timeout};

   step_t q[$];
   int    errors = 0;
   int    checks = 0;
   string tag = "init";

   function automatic void push(input logic [5:0] code, input logic rdy, input strb_t s);
      step_t st;
      st.code = code;
      st.rdy  = rdy;
      st.exp  = s;
      q.push_back(st);
   endfunction

   function automatic logic rnd_bit();
      return logic'($urandom_range(0, 1));
   endfunction

   // A memory access: `waits` stalled cycles then the completing one; `done` adds the ready-gated strobes.
   function automatic void mem_access(input logic [5:0] code, input strb_t base, input strb_t done,
                                      input int unsigned waits);
      for (int unsigned i = 0; i < waits; i++) push(code, 1'b0, base);
      push(code, 1'b1, base | done);
   endfunction

   function automatic void add_fetch(input int unsigned waits);
      strb_t b, d;
      b = '0; b.mem_req = 1'b1; b.alu_src_b = 2'b01;
      d = '0; d.ir_write = 1'b1; d.pc_write = 1'b1;
      mem_access(6'd1, b, d, waits);
   endfunction

   function automatic void add_decode();
      strb_t s;
      s = '0; s.a_write = 1'b1; s.b_write = 1'b1; s.alu_out_load = 1'b1; s.alu_src_b = 2'b11;
      push(6'd2, rnd_bit(), s);
   endfunction

   function automatic void add_mem_addr();
      strb_t s;
      s = '0; s.alu_src_a = 1'b1; s.alu_src_b = 2'b10; s.alu_out_load = 1'b1;
      push(6'd5, rnd_bit(), s);
   endfunction

   // Instruction classes: 0 R, 1 LW, 2 SW, 3 BEQ, 4 BNE, 5 J, 6 LUI
   function automatic void build_instr(input int unsigned cls, input int unsigned fw,
                                       input int unsigned mw);
      strb_t s, z;
      z = '0;
      add_fetch(fw);
      add_decode();
      s = '0;
      case (cls)
         0: begin
            s.alu_src_a = 1'b1; s.alu_op = 3'b010; s.alu_out_load = 1'b1;
            push(6'd3, rnd_bit(), s);
            s = '0; s.reg_write = 1'b1; s.reg_dst = 1'b1;
            push(6'd4, rnd_bit(), s);
         end
         1: begin
            add_mem_addr();
            s.mem_req = 1'b1; s.iord = 1'b1;
            mem_access(6'd6, s, z, mw);
            s = '0; s.reg_write = 1'b1; s.mem_to_reg = 2'b01;
            push(6'd7, rnd_bit(), s);
         end
         2: begin
            add_mem_addr();
            s.mem_req = 1'b1; s.mem_write = 1'b1; s.iord = 1'b1;
            mem_access(6'd8, s, z, mw);
         end
         3, 4: begin
            s.alu_src_a = 1'b1; s.alu_op = 3'b001; s.pc_write_cond = 1'b1; s.pc_source = 2'b01;
            s.branch_ne = (cls == 4);
            push((cls == 4) ? 6'd10 : 6'd9, rnd_bit(), s);
         end
         5: begin
            s.pc_write = 1'b1; s.pc_source = 2'b10;
            push(6'd11, rnd_bit(), s);
         end
         default: begin
            s.reg_write = 1'b1; s.mem_to_reg = 2'b10;
            push(6'd12, rnd_bit(), s);
         end
      endcase
   endfunction

   function automatic logic [5:0] op_of(input int unsigned cls);
      case (cls)
         0:       return 6'h00;
         1:       return 6'h23;
         2:       return 6'h2B;
         3:       return 6'h04;
         4:       return 6'h05;
         5:       return 6'h02;
         default: return 6'h0F;
      endcase
   endfunction

   // Runs the queued trace: drive mem_ready on the falling edge, compare 1 time unit later.
   task automatic run_trace();
      step_t st;
      while (q.size() > 0) begin
         st = q.pop_front();
         mem_ready = st.rdy;
         #1;
         checks++;
         assert (state_out === st.code)
            else begin errors++; $error("FAIL %s state: observed %0d expected %0d", tag, state_out, st.code); end
         checks++;
         assert (act === st.exp)
            else begin errors++; $error("FAIL %s strobes: observed %h expected %h", tag, act, st.exp); end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic check_reset_state();
      #1;
      checks++;
      assert (state_out === 6'd0)
         else begin errors++; $error("FAIL %s reset_state: observed %0d expected 0", tag, state_out); end
      checks++;
      assert (act === strb_t'('0))
         else begin errors++; $error("FAIL %s reset_strobes: observed %h expected 0", tag, act); end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      mem_ready = rnd_bit();
      @(posedge clk);
      @(negedge clk);
      check_reset_state();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_instr(input int unsigned cls, input int unsigned fw, input int unsigned mw);
      logic [5:0] f;
      op = op_of(cls);
      f = 6'($urandom_range(0, 63));
      if (cls == 0 && f == 6'h0D) f = 6'h20;
      funct = f;
      build_instr(cls, fw, mw);
      run_trace();
   endtask

   initial begin
      strb_t s;

      tag = "reset";
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_state();
      @(posedge clk);
      @(negedge clk);
      check_reset_state();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);

      tag = "add";
      op = 6'h00; funct = 6'h20;
      build_instr(0, 0, 0);
      run_trace();

      tag = "lw_wait3";
      op = 6'h23; funct = 6'h00;
      build_instr(1, 0, 3);
      run_trace();

      tag = "bne";
      do_instr(4, 0, 0);
      tag = "beq";
      do_instr(3, 1, 0);
      tag = "sw_wait";
      do_instr(2, 2, 2);
      tag = "j";
      do_instr(5, 0, 0);
      tag = "lui";
      do_instr(6, 3, 0);

      tag = "random";
      for (int i = 0; i < 60; i++)
         do_instr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));

      tag = "reset_in_wait";
      op = 6'h00; funct = 6'h20;
      s = '0; s.mem_req = 1'b1; s.alu_src_b = 2'b01;
      push(6'd1, 1'b0, s);
      push(6'd1, 1'b0, s);
      run_trace();
      do_reset();

      tag = "illegal";
      op = 6'h3F; funct = 6'($urandom_range(0, 63));
      add_fetch(1);
      add_decode();
      s = '0; s.illegal = 1'b1;
      for (int i = 0; i < 10; i++) push(6'd14, rnd_bit(), s);
      run_trace();
      do_reset();

      tag = "break";
      op = 6'h00; funct = 6'h0D;
      add_fetch(0);
      add_decode();
      s = '0; s.brk = 1'b1;
      for (int i = 0; i < 6; i++) push(6'd13, rnd_bit(), s);
      run_trace();
      do_reset();

      tag = "after_halt";
      do_instr(0, 0, 0);

`ifdef MC_CTRL_TIMEOUT_EN
      tag = "fetch_timeout";
      s = '0; s.mem_req = 1'b1; s.alu_src_b = 2'b01;
      for (int i = 0; i < 4; i++) push(6'd1, 1'b0, s);
      s = '0; s.mem_timeout = 1'b1;
      for (int i = 0; i < 4; i++) push(6'd14, rnd_bit(), s);
      run_trace();
      do_reset();

      tag = "lw_timeout";
      op = 6'h23;
      add_fetch(2);
      add_decode();
      add_mem_addr();
      s = '0; s.mem_req = 1'b1; s.iord = 1'b1;
      for (int i = 0; i < 4; i++) push(6'd6, 1'b0, s);
      s = '0; s.mem_timeout = 1'b1;
      for (int i = 0; i < 3; i++) push(6'd14, rnd_bit(), s);
      run_trace();
      do_reset();

      tag = "after_timeout";
      do_instr(2, 3, 3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
